instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/wait_timer.sv | 36 +++
 rtl/instr_sequencer.sv | 137 +++++++++++++
 tb/tb_instr_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I base-opcode constants, sequencer state encoding and trap-cause codes.
package riscv_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM_TO = 2'b10,
        CAUSE_DMEM_TO = 2'b11
    } trap_cause_e;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_opcode = 1'b1;
            default:                           is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Stall counter for memory handshakes; saturates once it has counted TIMEOUT idle cycles.
module wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == CW'(TIMEOUT));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction control FSM: fetch/decode/execute/mem/writeback with
// memory-timeout and illegal-opcode traps, plus a retired-instruction counter.
module instr_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [6:0]  opcode,
    input  logic        reg_wr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_en,
    output logic        pc_en,
    output logic        rf_we,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    seq_state_e  state_q;
    seq_state_e  state_d;
    trap_cause_e cause_q;
    trap_cause_e cause_d;
    logic [31:0] retired_q;
    logic        wait_inc;
    logic        wait_expired;

    // Any cycle that is not a stalled handshake clears the timer, which covers entry to FETCH and MEM.
    assign wait_inc = ((state_q == ST_FETCH) && !imem_ready) ||
                      ((state_q == ST_MEM)   && !dmem_ready);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (!wait_inc),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_en   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (is_legal_opcode(opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                if (mem_rd || mem_wr) begin
                    state_d = ST_MEM;
                end else if (reg_wr) begin
                    state_d = ST_WB;
                end else begin
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_wr;
                // A simultaneous read+write request is resolved as a store.
                if (dmem_ready) begin
                    if (mem_wr) begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_FETCH;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (pc_en) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised scoreboard bench: a rule-based timing model predicts each instruction's outcome.
module tb_instr_sequencer;
    import riscv_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [6:0]  opcode = '0;
    logic        reg_wr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_en, pc_en, rf_we, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] retired;

    always #5 clk = ~clk;

    instr_sequencer #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .opcode     (opcode),
        .reg_wr     (reg_wr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .rf_we      (rf_we),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state),
        .retired    (retired)
    );

    typedef struct {
        int          lat;
        int          ir_idx;
        int          rf_cnt;
        int          dreq;
        bit          dwe;
        bit          is_trap;
        logic [1:0]  cause;
        logic [31:0] ret_before;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          quiet_viol = 0;
    logic [31:0] model_retired = '0;
    logic [6:0]  legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic bit legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: accumulates per-instruction observations and compares on retire or trap.
    initial begin
        int rel = 0, ir_idx = -1, rf_cnt = 0, dreq = 0;
        bit dwe = 0, trap_seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                rel = 0; ir_idx = -1; rf_cnt = 0; dreq = 0; dwe = 0; trap_seen = 0;
                quiet_viol = 0;
            end else if (trap_seen) begin
                if (imem_req || dmem_req || dmem_we || ir_en || pc_en || rf_we) quiet_viol++;
            end else begin
                if (ir_en) ir_idx = rel;
                if (dmem_req) begin dreq++; dwe |= dmem_we; end
                if (rf_we) rf_cnt++;
                if (pc_en || trap) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", 32'(rel), 32'(e.lat));
                        check("ir_en_cycle", 32'(ir_idx), 32'(e.ir_idx));
                        check("rf_we_cycles", 32'(rf_cnt), 32'(e.rf_cnt));
                        check("dmem_req_cycles", 32'(dreq), 32'(e.dreq));
                        check("dmem_we", 32'(dwe), 32'(e.dwe));
                        check("trap_flag", 32'(trap), 32'(e.is_trap));
                        if (e.is_trap) check("trap_cause", 32'(trap_cause), 32'(e.cause));
                        else           check("retired", retired, e.ret_before);
                    end
                    if (trap) trap_seen = 1;
                    rel = 0; ir_idx = -1; rf_cnt = 0; dreq = 0; dwe = 0;
                end else begin
                    rel++;
                end
            end
        end
    end

    task automatic do_reset();
        n_rst = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_q.delete();
        model_retired = '0;
        @(negedge clk);
        check("rst_state", 32'(state), 32'(ST_FETCH));
        check("rst_retired", retired, 32'(0));
        check("rst_trap", 32'(trap), 32'(0));
        check("rst_cause", 32'(trap_cause), 32'(0));
        @(posedge clk); #1;
        n_rst = 1'b1;
        #1;
        check("imem_req_after_release", 32'(imem_req), 32'(1));
    endtask

    // Drives one instruction from its fetch cycle; di/dd are the imem/dmem stall lengths.
    task automatic run_instr(input logic [6:0] op, input bit rw, input bit mr, input bit mw,
                             input int di, input int dd);
        exp_t e;
        bit   is_mem;
        int   ms, mend;
        e = '{default: 0};
        e.ir_idx = -1;
        e.ret_before = model_retired;
        if (di > TO) begin
            e.is_trap = 1; e.cause = 2'b10; e.lat = TO + 1;
        end else begin
            e.ir_idx = di;
            if (!legal(op)) begin
                e.is_trap = 1; e.cause = 2'b01; e.lat = di + 2;
            end else if (mr || mw) begin
                e.dreq = (dd > TO) ? TO + 1 : dd + 1;
                e.dwe  = mw;
                if (dd > TO)  begin e.is_trap = 1; e.cause = 2'b11; e.lat = di + 4 + TO; end
                else if (mw)  e.lat = di + 3 + dd;
                else begin    e.lat = di + 4 + dd; e.rf_cnt = 1; end
            end else if (rw) begin
                e.lat = di + 3; e.rf_cnt = 1;
            end else begin
                e.lat = di + 2;
            end
        end
        if (!e.is_trap) model_retired++;
        exp_q.push_back(e);
        opcode = op; reg_wr = rw; mem_rd = mr; mem_wr = mw;
        is_mem = legal(op) && (di <= TO) && (mr || mw);
        ms   = di + 3;
        mend = ms + ((dd > TO) ? TO : dd);
        for (int k = 0; k <= e.lat; k++) begin
            if (k <= di && k <= TO) imem_ready = (k == di);
            else imem_ready = 1'($urandom_range(0, 1));
            if (is_mem && k >= ms && k <= mend) dmem_ready = (k == ms + dd);
            else dmem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        if (e.is_trap) begin
            repeat (20) begin
                imem_ready = 1'($urandom_range(0, 1));
                dmem_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            check("trap_held", 32'(trap), 32'(1));
            check("trap_state", 32'(state), 32'(ST_TRAP));
            check("trap_cause_held", 32'(trap_cause), 32'(e.cause));
            check("trap_quiet", 32'(quiet_viol), 32'(0));
            do_reset();
        end
    endtask

    task automatic reset_mid_mem();
        repeat (5) run_instr(7'h33, 1, 0, 0, 0, 0);
        opcode = 7'h23; reg_wr = 0; mem_rd = 0; mem_wr = 1;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_mem_state", 32'(state), 32'(ST_MEM));
        check("mid_mem_dmem_req", 32'(dmem_req), 32'(1));
        check("mid_mem_retired", retired, 32'(5));
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'(ST_FETCH));
        check("async_rst_dmem_req", 32'(dmem_req), 32'(0));
        check("async_rst_retired", retired, 32'(0));
        @(posedge clk); #1;
        do_reset();
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return 0;
        if (r < 17) return $urandom_range(1, TO - 1);
        if (r < 19) return TO;
        return TO + 1;
    endfunction

    initial begin
        @(posedge clk); #1;
        do_reset();
        run_instr(7'h33, 1, 0, 0, 0, 0);       // ADD
        run_instr(7'h03, 1, 1, 0, 0, 3);       // LW, dmem stalls 3
        run_instr(7'h63, 0, 0, 0, 0, 0);       // BEQ
        run_instr(7'h23, 0, 1, 1, 1, 1);       // read+write resolves as store
        run_instr(7'h13, 1, 0, 0, TO, 0);      // imem ready on last allowed cycle
        run_instr(7'h03, 1, 1, 0, 0, TO);      // dmem ready on last allowed cycle
        run_instr(7'h7F, 1, 1, 0, 0, 0);       // illegal opcode
        run_instr(7'h33, 1, 0, 0, TO + 1, 0);  // imem timeout
        run_instr(7'h23, 0, 0, 1, 0, TO + 1);  // dmem timeout
        reset_mid_mem();
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
            else op = legal_ops[$urandom_range(0, 8)];
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), pick_delay(), pick_delay());
        end
        @(posedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
